gate_response_checker: RTL and testbench
========================================

GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 Parameter SAMPLES, default 16, SHALL set the number of compared cycles per run (legal range 1..255).
REQ-002 Parameter LATENCY, default 1, SHALL set the DUT delay in cycles from stim to resp (legal range 1..8).
REQ-003 Parameter CNT_W, default 8, SHALL set the width of err_count.
REQ-004 Port clock, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-006 Port start, input, 1, SHALL be a one-cycle request to begin a run.
REQ-007 Port stim, input, 1, SHALL carry the stimulus bit that the bench drives into the gate under test.
REQ-008 Port resp, input, 1, SHALL carry the output of the gate under test.
REQ-009 Port busy, output, 1, SHALL be high in every state except IDLE.
REQ-010 Port done, output, 1, SHALL pulse high for exactly one cycle at the end of a run.
REQ-011 Port pass, output, 1, SHALL report the result of the last completed run (1 = zero errors).
REQ-012 Port err_count, output, CNT_W, SHALL report the number of mismatches in the current or last run.

Function
REQ-013 The block SHALL implement the states IDLE, FILL, CHECK and DONE.
REQ-014 State transitions SHALL be:
- IDLE to FILL on start=1.
- FILL to CHECK after exactly LATENCY cycles.
- CHECK to DONE after exactly SAMPLES cycles.
- DONE to IDLE after one cycle.
REQ-015 stim SHALL feed a free-running delay line of LATENCY registers, so stim_d equals stim from LATENCY cycles earlier.
REQ-016 In each CHECK cycle the block SHALL compare resp against ~stim_d; a mismatch SHALL increment err_count.
REQ-017 err_count SHALL saturate at all-ones and never wrap.
REQ-018 On accepting start, err_count and pass SHALL clear to 0 in the following cycle.
REQ-019 done SHALL assert in the DONE state, i.e. 1+LATENCY+SAMPLES cycles after the edge at which start was sampled.
REQ-020 On entry to DONE, pass SHALL load (err_count==0).
REQ-021 pass and err_count SHALL hold their values in IDLE until the next accepted start.
REQ-022 start SHALL be ignored in FILL, CHECK and DONE; it is accepted only in IDLE.
REQ-023 The last CHECK-cycle mismatch SHALL be counted before pass is evaluated; compare and count are registered together.

Reset
REQ-024 While reset_n=0, the following SHALL hold regardless of clock:
- state = IDLE.
- busy = 0, done = 0, pass = 0.
- err_count = 0, delay line = 0.
- sample counter = 0.
REQ-025 Reset asserted mid-run SHALL abort the run; no done pulse SHALL follow reset release.

Configuration
REQ-026 With GATE_CHECKER_FIRST_ERR_EN defined:
- Output first_err_idx, width 8, SHALL capture the CHECK-cycle index (0-based) of the first mismatch of the run.
- Output first_err_vld SHALL be set when first_err_idx is captured.
- Both SHALL clear on an accepted start and on reset.
REQ-027 Without GATE_CHECKER_FIRST_ERR_EN, neither port nor the capture logic SHALL exist.

Structure
REQ-028 A shared package gate_check_pkg SHALL hold the state enum typedef (IDLE, FILL, CHECK, DONE) and the limit constants MAX_SAMPLES=255 and MAX_LATENCY=8.
REQ-029 The delay line SHALL be a sub-module stim_delay_line, parameterised by LATENCY; all other logic SHALL be flat.

Verification
REQ-030 Ideal inverter, LATENCY=1, SAMPLES=16, stim toggling every cycle, resp = registered ~stim -> done at cycle 18 after start; pass=1; err_count=0.
REQ-031 resp stuck at 0, stim toggling -> err_count=8; pass=0.
REQ-032 CNT_W=3, SAMPLES=16, resp = delayed stim (non-inverting gate) -> err_count saturates at 7; pass=0.
REQ-033 start pulsed in FILL, in CHECK and in the DONE cycle -> exactly one done pulse; a start in the following IDLE cycle begins a new run.
REQ-034 reset_n low for 2 cycles mid-CHECK -> busy=0, err_count=0, pass=0; no done pulse afterwards.
REQ-035 With GATE_CHECKER_FIRST_ERR_EN defined, a single mismatch injected at CHECK index 5 -> first_err_idx=5, first_err_vld=1, err_count=1.

Source files
------------

// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared state encoding and limit constants for the gate response checker
package gate_check_pkg;

    localparam int MAX_SAMPLES = 255;
    localparam int MAX_LATENCY = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/stim_delay_line.sv
// rtl/stim_delay_line.sv - free-running shift register that delays stim by LATENCY cycles
module stim_delay_line #(
    parameter int LATENCY = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic stim,
    output logic stim_dly
);

    logic [LATENCY-1:0] taps_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            taps_q <= '0;
        end else begin
            taps_q[0] <= stim;
            for (int i = 1; i < LATENCY; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    assign stim_dly = taps_q[LATENCY-1];

endmodule

// File: rtl/gate_response_checker.sv
// rtl/gate_response_checker.sv - checks an inverting gate's response against delayed stimulus
// Optional first-mismatch capture ports: GATE_CHECKER_FIRST_ERR_EN
module gate_response_checker
    import gate_check_pkg::*;
#(
    parameter int SAMPLES = 16,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stim,
    input  logic             resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count
`ifdef GATE_CHECKER_FIRST_ERR_EN
    ,
    output logic [7:0]       first_err_idx,
    output logic             first_err_vld
`endif
);

    localparam int CW = $clog2(MAX_SAMPLES + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic             stim_dly;
    logic             mismatch;

    stim_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clock    (clock),
        .reset_n  (reset_n),
        .stim     (stim),
        .stim_dly (stim_dly)
    );

    // A healthy gate inverts, so resp equal to the delayed stim is an error.
    assign mismatch = (resp == stim_dly);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            FILL: begin
                if (cnt_q == CW'(LATENCY - 1)) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: begin
                if (mismatch && !(&err_q)) begin
                    err_d = err_q + 1'b1;
                end
                // Evaluate pass on the updated count so the final sample is included.
                if (cnt_q == CW'(SAMPLES - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    pass_d  = (err_d == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign err_count = err_q;

`ifdef GATE_CHECKER_FIRST_ERR_EN
    logic [7:0] fe_idx_q, fe_idx_d;
    logic       fe_vld_q, fe_vld_d;

    always_comb begin
        fe_idx_d = fe_idx_q;
        fe_vld_d = fe_vld_q;
        if (state_q == IDLE && start) begin
            fe_idx_d = '0;
            fe_vld_d = 1'b0;
        end else if (state_q == CHECK && mismatch && !fe_vld_q) begin
            fe_idx_d = 8'(cnt_q);
            fe_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fe_idx_q <= '0;
            fe_vld_q <= 1'b0;
        end else begin
            fe_idx_q <= fe_idx_d;
            fe_vld_q <= fe_vld_d;
        end
    end

    assign first_err_idx = fe_idx_q;
    assign first_err_vld = fe_vld_q;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// tb/tb_gate_response_checker.sv - directed self-checking bench for gate_response_checker
module tb_gate_response_checker;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic       stim;
    logic       inject;
    int         mode;
    logic       gate_a_q = 1'b0;
    logic       gate_b_q = 1'b0;
    logic       resp_a, resp_b;
    logic       busy_a, done_a, pass_a;
    logic [7:0] err_a;
    logic       busy_b, done_b, pass_b;
    logic [2:0] err_b;
`ifdef GATE_CHECKER_FIRST_ERR_EN
    logic [7:0] fe_idx_a, fe_idx_b;
    logic       fe_vld_a, fe_vld_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    // Gate models: a: registered inverter (mode 1 = stuck at 0), b: registered buffer
    always @(posedge clock) begin
        gate_a_q <= ~stim;
        gate_b_q <= stim;
    end
    assign resp_a = (mode == 1) ? 1'b0 : (gate_a_q ^ inject);
    assign resp_b = gate_b_q;

    gate_response_checker #(.SAMPLES(16), .LATENCY(1), .CNT_W(8)) u_dut_a (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .stim          (stim),
        .resp          (resp_a),
        .busy          (busy_a),
        .done          (done_a),
        .pass          (pass_a),
        .err_count     (err_a)
`ifdef GATE_CHECKER_FIRST_ERR_EN
        ,
        .first_err_idx (fe_idx_a),
        .first_err_vld (fe_vld_a)
`endif
    );

    gate_response_checker #(.SAMPLES(16), .LATENCY(1), .CNT_W(3)) u_dut_b (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .stim          (stim),
        .resp          (resp_b),
        .busy          (busy_b),
        .done          (done_b),
        .pass          (pass_b),
        .err_count     (err_b)
`ifdef GATE_CHECKER_FIRST_ERR_EN
        ,
        .first_err_idx (fe_idx_b),
        .first_err_vld (fe_vld_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        stim = ~stim;
    endtask

    // Cycle c=1 is the cycle that begins at the edge sampling the initial start.
    task automatic run(input int win, input int s0, input int s1, input int s2, input int s3,
                       input int inj_c, output int ndone, output int d0, output int d1,
                       output int b1, output int e1, output int p1);
        ndone = 0; d0 = -1; d1 = -1; b1 = -1; e1 = -1; p1 = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= win; c++) begin
            if (done_a) begin
                if (ndone == 0) d0 = c;
                else if (ndone == 1) d1 = c;
                ndone++;
            end
            if (c == 1) begin
                b1 = int'(busy_a);
                e1 = int'(err_a);
                p1 = int'(pass_a);
            end
            start  = (c == s0 || c == s1 || c == s2 || c == s3);
            inject = (c == inj_c);
            tick();
        end
        start  = 1'b0;
        inject = 1'b0;
    endtask

    initial begin
        int nd, d0, d1, b1, e1, p1, ndr;
        reset_n = 1'b0; start = 1'b0; stim = 1'b0; inject = 1'b0; mode = 0;
        repeat (3) tick();
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_a, 0);
        reset_n = 1'b1;
        tick();

        // Ideal inverter; instance b sees a buffer and saturates its 3-bit count
        mode = 0;
        run(20, 0, 0, 0, 0, 0, nd, d0, d1, b1, e1, p1);
        check("t1_done_cycle", d0, 18);
        check("t1_done_count", nd, 1);
        check("t1_busy_fill", b1, 1);
        check("t1_pass", pass_a, 1);
        check("t1_err", err_a, 0);
        check("t1_idle_busy", busy_a, 0);
        check("sat_err_b", err_b, 7);
        check("sat_pass_b", pass_b, 0);

        // Stuck-at-0 response: half the samples mismatch
        mode = 1;
        run(20, 0, 0, 0, 0, 0, nd, d0, d1, b1, e1, p1);
        check("t2_err", err_a, 8);
        check("t2_pass", pass_a, 0);
        repeat (3) tick();
        check("t2_hold_err", err_a, 8);
        check("t2_hold_pass", pass_a, 0);

        // New run clears the previous result one cycle after start
        mode = 0;
        run(20, 0, 0, 0, 0, 0, nd, d0, d1, b1, e1, p1);
        check("t3_clear_err", e1, 0);
        check("t3_clear_pass", p1, 0);
        check("t3_pass", pass_a, 1);
        check("t3_err", err_a, 0);

        // Starts in FILL, CHECK, DONE are ignored; start in the next IDLE cycle runs again
        run(45, 1, 5, 18, 19, 0, nd, d0, d1, b1, e1, p1);
        check("t4_done_count", nd, 2);
        check("t4_first_done", d0, 18);
        check("t4_second_done", d1, 37);

        // Single mismatch at CHECK index 5
        run(20, 0, 0, 0, 0, 7, nd, d0, d1, b1, e1, p1);
        check("t5_err", err_a, 1);
        check("t5_pass", pass_a, 0);
`ifdef GATE_CHECKER_FIRST_ERR_EN
        check("t5_first_idx", fe_idx_a, 5);
        check("t5_first_vld", fe_vld_a, 1);
`endif

        // Reset mid-CHECK aborts the run
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("t6_pre_busy", busy_a, 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_busy", busy_a, 0);
        check("t6_rst_err", err_a, 0);
        check("t6_rst_pass", pass_a, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        ndr = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done_a) ndr++;
        end
        check("t6_no_done", ndr, 0);
        check("t6_post_busy", busy_a, 0);
        check("t6_post_err", err_a, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
